// File: rtl/uart_pkg.sv
// uart_pkg: state encoding and widths shared by the uart transmit and receive paths
package uart_pkg;
  localparam int UART_DATA_W = 8;
  localparam int UART_TICK_W = 16;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_t;
endpackage

// File: rtl/uart_tx_tick.sv
// uart_tx_tick: bit-period counter strobing on the last cycle of each bit
module uart_tx_tick
  import uart_pkg::*;
(
  input  logic                   iCLK,
  input  logic                   iRESETn,
  input  logic                   clr,
  input  logic                   en,
  input  logic [UART_TICK_W-1:0] tick_cnt,
  output logic                   strobe
);
  logic [UART_TICK_W-1:0] cnt;
  assign strobe = en && cnt == tick_cnt;
  always_ff @(posedge iCLK)
    if (!iRESETn || clr) cnt <= '0;
    else if (en) cnt <= strobe ? '0 : cnt + UART_TICK_W'(1);
endmodule

// File: rtl/uart_tx_frame.sv
// uart_tx_frame: start/data/parity/stop serializer with start/busy/done handshake
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int DATA_W = UART_DATA_W
) (
  input  logic                   iCLK,
  input  logic                   iRESETn,
  input  logic                   iTX_START,
  input  logic [DATA_W-1:0]      iTX_DATA,
  input  logic [UART_TICK_W-1:0] iTICK_CNT,
  input  logic                   iPARITY_EN,
  input  logic                   iPARITY_ODD,
  input  logic                   iSTOP2,
  output logic                   oUART_TX,
  output logic                   oTX_BUSY,
  output logic                   oTX_DONE
);
  tx_state_t state, state_n;
  logic [DATA_W-1:0] sh, sh_n;
  logic [2:0] idx, idx_n;
  logic stop_cnt, stop_n, par, pen, stop2, accept, strobe, tx_n;
  logic [UART_TICK_W-1:0] tick;
  assign accept = state == IDLE && iTX_START;
  uart_tx_tick u_tick (
    .iCLK,
    .iRESETn,
    .clr(accept),
    .en(state != IDLE),
    .tick_cnt(tick),
    .strobe
  );
  always_comb begin
    state_n = state;
    sh_n = sh;
    idx_n = idx;
    stop_n = stop_cnt;
    case (state)
      IDLE: if (accept) begin
        state_n = START;
        sh_n = iTX_DATA;
      end
      START: if (strobe) state_n = DATA;
      DATA: if (strobe) begin
        sh_n = sh >> 1;
        idx_n = idx + 3'd1;
        if (idx == 3'(DATA_W - 1)) state_n = pen ? PARITY : STOP;
      end
      PARITY: if (strobe) state_n = STOP;
      STOP: if (strobe) begin
        stop_n = ~stop_cnt;
        if (stop_cnt == stop2) begin
          state_n = IDLE;
          stop_n = 1'b0;
        end
      end
      default: state_n = IDLE;
    endcase
    // line level follows the state being entered so the output stays registered
    tx_n = state_n == START ? 1'b0 : state_n == DATA ? sh_n[0] : state_n == PARITY ? par : 1'b1;
  end
  always_ff @(posedge iCLK)
    if (!iRESETn) begin
      state <= IDLE;
      sh <= '0;
      idx <= '0;
      stop_cnt <= 1'b0;
      par <= 1'b0;
      pen <= 1'b0;
      stop2 <= 1'b0;
      tick <= '0;
      oUART_TX <= 1'b1;
      oTX_BUSY <= 1'b0;
      oTX_DONE <= 1'b0;
    end else begin
      state <= state_n;
      sh <= sh_n;
      idx <= idx_n;
      stop_cnt <= stop_n;
      if (accept) begin
        tick <= iTICK_CNT;
        pen <= iPARITY_EN;
        stop2 <= iSTOP2;
        par <= ^iTX_DATA ^ iPARITY_ODD;
      end
      oUART_TX <= tx_n;
      oTX_BUSY <= state_n != IDLE;
      oTX_DONE <= state == STOP && state_n == IDLE;
    end
endmodule

// File: tb/tb_uart_tx_frame.sv
// tb_uart_tx_frame: per-cycle scoreboard of line, busy and done against a frame model
module tb_uart_tx_frame;
  typedef struct packed {logic tx; logic busy; logic done;} exp_t;
  logic iCLK = 1'b0, iRESETn = 1'b0, iTX_START = 1'b0;
  logic [7:0] iTX_DATA = '0;
  logic [15:0] iTICK_CNT = '0;
  logic iPARITY_EN = 1'b0, iPARITY_ODD = 1'b0, iSTOP2 = 1'b0;
  logic oUART_TX, oTX_BUSY, oTX_DONE;
  int checks = 0, errors = 0;
  exp_t q[$];
  uart_tx_frame dut (
    .iCLK, .iRESETn, .iTX_START, .iTX_DATA, .iTICK_CNT,
    .iPARITY_EN, .iPARITY_ODD, .iSTOP2, .oUART_TX, .oTX_BUSY, .oTX_DONE
  );
  always #5 iCLK = ~iCLK;
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  task automatic compare(input string name, input int k);
    exp_t e;
    e = q.pop_front();
    checks += 3;
    if (oUART_TX !== e.tx) begin
      errors++;
      $display("FAIL %s line cycle %0d: got %b expected %b", name, k, oUART_TX, e.tx);
    end
    if (oTX_BUSY !== e.busy) begin
      errors++;
      $display("FAIL %s busy cycle %0d: got %b expected %b", name, k, oTX_BUSY, e.busy);
    end
    if (oTX_DONE !== e.done) begin
      errors++;
      $display("FAIL %s done cycle %0d: got %b expected %b", name, k, oTX_DONE, e.done);
    end
  endtask
  task automatic push_frame(input logic [7:0] d, input int t, input logic pe, po, s2, input int upto);
    logic [11:0] bits;
    int f;
    f = 10 + int'(pe) + int'(s2);
    bits = '1;
    bits[0] = 1'b0;
    bits[8:1] = d;
    if (pe) bits[9] = ^d ^ po;
    for (int k = 1; k <= f * t && k <= upto; k++) q.push_back({bits[(k-1)/t], 1'b1, 1'b0});
    if (upto > f * t) q.push_back({1'b1, 1'b0, 1'b1});
  endtask
  task automatic run_frame(input string name, input logic [7:0] d, input logic [15:0] tc,
                           input logic pe, po, s2, input bit hold, input bit mutate);
    int t, n;
    t = int'(tc) + 1;
    n = (10 + int'(pe) + int'(s2)) * t + 1;
    push_frame(d, t, pe, po, s2, n);
    iTX_START = 1'b1;
    iTX_DATA = d;
    iTICK_CNT = tc;
    iPARITY_EN = pe;
    iPARITY_ODD = po;
    iSTOP2 = s2;
    for (int k = 1; k <= n; k++) begin
      @(negedge iCLK);
      compare(name, k);
      if (k == 1 && !hold) iTX_START = 1'b0;
      if (mutate && k == 2 * t) begin
        iTX_DATA = ~d;
        iTICK_CNT = tc + 16'd3;
        iPARITY_EN = ~pe;
        iPARITY_ODD = ~po;
        iSTOP2 = ~s2;
      end
    end
  endtask
  task automatic test_reset;
    iRESETn = 1'b0;
    iTX_START = 1'b1;
    repeat (3) @(negedge iCLK);
    q.push_back({1'b1, 1'b0, 1'b0});
    compare("reset", 0);
    iTX_START = 1'b0;
    iRESETn = 1'b1;
    @(negedge iCLK);
    q.push_back({1'b1, 1'b0, 1'b0});
    compare("idle", 0);
  endtask
  task automatic test_basic;
    run_frame("basic", 8'hA5, 16'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask
  task automatic test_parity;
    run_frame("parity_even", 8'hA5, 16'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    run_frame("parity_odd", 8'hA5, 16'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    run_frame("parity_odd_stop2", 8'h3C, 16'd1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
  endtask
  task automatic test_stop2;
    run_frame("stop2", 8'h00, 16'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask
  task automatic test_back_to_back;
    run_frame("b2b_first", 8'h55, 16'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    run_frame("b2b_second", 8'h0F, 16'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask
  task automatic test_stability;
    run_frame("stability", 8'hC3, 16'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask
  task automatic test_random;
    for (int i = 0; i < 4; i++)
      run_frame("random", 8'($urandom), 16'($urandom_range(0, 3)), 1'($urandom),
                1'($urandom), 1'($urandom), 1'b0, 1'b0);
  endtask
  task automatic test_mid_reset;
    push_frame(8'hA5, 4, 1'b0, 1'b0, 1'b0, 18);
    repeat (4) q.push_back({1'b1, 1'b0, 1'b0});
    iTX_START = 1'b1;
    iTX_DATA = 8'hA5;
    iTICK_CNT = 16'd3;
    iPARITY_EN = 1'b0;
    iSTOP2 = 1'b0;
    for (int k = 1; k <= 22; k++) begin
      @(negedge iCLK);
      compare("mid_reset", k);
      if (k == 1) iTX_START = 1'b0;
      if (k == 18) iRESETn = 1'b0;
      if (k == 20) iRESETn = 1'b1;
    end
  endtask
  initial begin
    @(negedge iCLK);
    test_reset();
    test_basic();
    test_parity();
    test_stop2();
    test_back_to_back();
    test_stability();
    test_random();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
